// File: rtl/uart_pkg.sv
// Purpose: constants, FSM encodings and helpers shared by the UART transmit
//          and receive paths.
// Contents: DATA_W, BIT_CNT_W, PARITY_* codes, uart_state_e, bit_time().
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 16;

  // Parity selection codes
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Frame-sequencer states; unused encodings recover to ST_IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per serial bit (integer division)
  function automatic int unsigned bit_time(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Purpose: byte-stream valid/ready handshake into the UART transmitter.
// Signals: in_data  - byte to transmit (source holds it until accepted)
//          in_valid - in_data is valid
//          in_ready - sink can accept; transfer on in_valid && in_ready
interface uart_tx_fifo_ctrl_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Purpose: small byte FIFO with registered count and full/empty flags.
// Ports: clk, rst       - clock, async active-high reset
//        wr_en_i/wr_data_i - write request (ignored when full)
//        rd_en_i        - pop request (ignored when empty)
//        rd_data_o      - head entry, valid while !empty_o
//        full_o/empty_o - decoded from the registered count
//        count_o        - entries held
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic                         rd_en_i,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Purpose: UART transmitter (8 data bits, optional parity, 1 or 2 stop bits)
//          fed from a byte FIFO; back-to-back frames leave no idle gap.
// Ports: clk, rst    - clock, async active-high reset
//        in_if       - byte handshake (slave side)
//        tx          - serial line, idle high, registered
//        busy        - frame in flight or bytes queued
//        done        - one-cycle pulse as the last stop bit completes
//        fifo_count  - bytes queued, excluding the frame in flight
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_fifo_ctrl_if.slave                in_if,
  output logic                              tx,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned       BIT_TIME = bit_time(CLK_FREQ, BAUD_RATE);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_TIME - 1);

  uart_state_e       state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              pop_c;
  logic              bit_end_c;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_if.in_valid),
    .wr_data_i (in_if.in_data),
    .rd_en_i   (pop_c),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign in_if.in_ready = !fifo_full;
  assign tx             = tx_q;
  assign done           = done_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;
  assign bit_end_c      = (cnt_q == BIT_LAST);

  // Frame sequencer: next state, next bit and FIFO pop
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    pop_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_c = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end_c) begin
          cnt_d     = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (bit_end_c) begin
          cnt_d      = '0;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (STOP_BITS == 2 && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              pop_c = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Popping a byte always launches a new start bit on the next edge
    if (pop_c) begin
      shift_d = fifo_rd_data;
      par_d   = (PARITY == PARITY_ODD) ? ~(^fifo_rd_data) : ^fifo_rd_data;
      tx_d    = 1'b0;
      cnt_d   = '0;
      state_d = ST_START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule
